// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode.
// Optional same-cycle bypass when the queue is empty is enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_pc,
    input  logic [31:0]               in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_inst,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;

    assign empty    = (cnt == '0);
    assign in_ready = (cnt != FULL);

`ifdef IFQ_BYPASS_EN
    // Gated by rst_n so outputs stay at their idle values while reset is held.
    assign bypass = rst_n && empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode takes in the same cycle never enters storage.
    assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
    assign pop  = !empty && out_ready && !flush;

    // NOTE: every output gets a default before the if-chain, so no latch is inferred.
    always_comb begin
        out_valid = !empty && !flush;
        out_pc    = 32'h0;
        out_inst  = NOP;
        if (!empty) begin
            out_pc   = mem_pc[rd_ptr];
            out_inst = mem_inst[rd_ptr];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; validity is tracked purely by pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= in_pc;
            mem_inst[wr_ptr] <= in_inst;
        end
    end

    assign count = cnt;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH 4); follows IFQ_BYPASS_EN if defined.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int compared   = 0;
    int mismatched = 0;

    inst_fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'hdead_beef;
        in_inst   = 32'hffff_ffff;
        out_ready = 1'b0;

        // Reset held 3 cycles with in_valid high
        repeat (3) step();
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_inst",  out_inst,       32'h0000_0013);
        chk("rst_out_pc",    out_pc,         32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // Fill to DEPTH with out_ready low
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(i * 4);
            in_inst  = 32'h1000 + 32'(i);
            step();
            if (i == 0) begin
                chk("fill_first_valid", 32'(out_valid), 32'd1);
                chk("fill_first_pc",    out_pc,         32'h0);
            end
        end
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_pc   = 32'h10;
        in_inst = 32'h1004;
        step();
        chk("full_ignore_count", 32'(count), 32'd4);

        // Drain in order
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc",   out_pc,   32'(i * 4));
            chk("drain_inst", out_inst, 32'h1000 + 32'(i));
            step();
        end
        chk("drain_count",     32'(count),     32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("empty_out_pc",    out_pc,         32'h0);
        chk("empty_out_inst",  out_inst,       32'h0000_0013);

        // Preload two words, then concurrent push/pop for 10 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pc   = 32'h100 + 32'(i * 4);
            in_inst = 32'h2000 + 32'(i);
            step();
        end
        chk("pre_conc_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc   = 32'h108 + 32'(k * 4);
            in_inst = 32'h2002 + 32'(k);
            #1;
            chk("conc_pc",   out_pc,   32'h100 + 32'(k * 4));
            chk("conc_inst", out_inst, 32'h2000 + 32'(k));
            step();
            chk("conc_count", 32'(count), 32'd2);
        end

        // Reach count 3, then flush with a push presented
        out_ready = 1'b0;
        in_pc     = 32'h130;
        in_inst   = 32'h3000;
        step();
        chk("pre_flush_count", 32'(count), 32'd3);
        flush     = 1'b1;
        in_pc     = 32'h200;
        in_inst   = 32'h4000;
        out_ready = 1'b1;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("post_flush_count", 32'(count),     32'd0);
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        chk("post_flush_pc",    out_pc,         32'h0);

        // Empty queue, in_valid and out_ready both high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'h400;
        in_inst   = 32'h0050_0093;
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_out_valid", 32'(out_valid), 32'd1);
        chk("byp_out_inst",  out_inst,       32'h0050_0093);
        chk("byp_out_pc",    out_pc,         32'h400);
        step();
        chk("byp_count", 32'(count), 32'd0);
        out_ready = 1'b0;
        in_pc     = 32'h404;
        in_inst   = 32'h0010_0113;
        step();
        in_valid = 1'b0;
        #1;
        chk("byp_store_count", 32'(count), 32'd1);
        chk("byp_store_pc",    out_pc,     32'h404);
        out_ready = 1'b1;
        step();
`else
        chk("nobyp_out_valid", 32'(out_valid), 32'd0);
        chk("nobyp_out_inst",  out_inst,       32'h0000_0013);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("nobyp_next_valid", 32'(out_valid), 32'd1);
        chk("nobyp_next_inst",  out_inst,       32'h0050_0093);
        chk("nobyp_next_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        step();
`endif
        chk("byp_end_count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle at count 3
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc   = 32'h500 + 32'(i * 4);
            in_inst = 32'h5000 + 32'(i);
            step();
        end
        chk("pre_arst_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        step();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h300;
        in_inst  = 32'h6000;
        step();
        in_valid = 1'b0;
        #1;
        chk("after_arst_count", 32'(count), 32'd1);
        chk("after_arst_pc",    out_pc,     32'h300);
        chk("after_arst_inst",  out_inst,   32'h6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
